micro_sequencer: RTL

//  Control sequencer for the 8-bit computer. Steps a T-state counter through

---
 rtl/micro_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - T-state sequencer driving bus enables of the 8-bit computer
// Fetch T0..T3 is common; execute steps are decoded per opcode from the current step.
module micro_sequencer #(
  parameter int STEP_W   = 4,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry,
  output logic                pc_oe,
  output logic                pc_we,
  output logic                pc_inc,
  output logic                mar_we,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ir_oe,
  output logic                ir_we,
  output logic                a_oe,
  output logic                a_we,
  output logic                b_we,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                out_we,
  output logic [STEP_W-1:0]   step,
  output logic                halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] T6 = STEP_W'(6);
  localparam logic [STEP_W-1:0] T7 = STEP_W'(7);
  localparam logic [STEP_W-1:0] T8 = STEP_W'(8);
  localparam logic [STEP_W-1:0] T9 = STEP_W'(9);

  state_t            state, state_next;
  logic [STEP_W-1:0] step_next;
  logic [STEP_W-1:0] last_step;
  logic              jc_taken, jc_taken_next;
  logic              active;
  logic              is_alu;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_RUN;
      step     <= T0;
      jc_taken <= 1'b0;
    end else begin
      state    <= state_next;
      step     <= step_next;
      jc_taken <= jc_taken_next;
    end
  end

  assign halted = (state == ST_HALT);
  assign active = en & ~clr & (state == ST_RUN);
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

  always_comb begin
    last_step = T3;
    case (opcode)
      OP_LDA, OP_STA:                 last_step = T7;
      OP_ADD, OP_SUB:                 last_step = T9;
      OP_LDI, OP_JMP, OP_JC, OP_OUT:  last_step = T5;
      OP_HLT:                         last_step = T4;
      default:                        last_step = T3;
    endcase
  end

  // Next-state: HALT is entered from T4 of HLT and only clr leaves it.
  always_comb begin
    state_next    = state;
    step_next     = step;
    jc_taken_next = jc_taken;
    if (state == ST_RUN && en) begin
      if (step > T9) begin
        step_next = T0;
      end else if (step == T4 && opcode == OP_HLT) begin
        state_next = ST_HALT;
      end else if (step == last_step) begin
        step_next = T0;
      end else begin
        step_next = step + STEP_W'(1);
      end
      if (step == T4) jc_taken_next = carry;
    end
  end

  // Strobe decode; the conditional jump is resolved at T4 and latched for T5.
  always_comb begin
    pc_oe   = 1'b0;
    pc_we   = 1'b0;
    pc_inc  = 1'b0;
    mar_we  = 1'b0;
    ram_oe  = 1'b0;
    ram_we  = 1'b0;
    ir_oe   = 1'b0;
    ir_we   = 1'b0;
    a_oe    = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    alu_oe  = 1'b0;
    alu_sub = 1'b0;
    out_we  = 1'b0;
    if (active && step <= last_step) begin
      case (step)
        T0: pc_oe  = 1'b1;
        T1: mar_we = 1'b1;
        T2: begin
          ram_oe = 1'b1;
          pc_inc = 1'b1;
        end
        T3: ir_we  = 1'b1;
        default: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              case (step)
                T4: ir_oe  = 1'b1;
                T5: mar_we = 1'b1;
                T6: begin
                  a_oe   = (opcode == OP_STA);
                  ram_oe = (opcode != OP_STA);
                end
                T7: begin
                  a_we   = (opcode == OP_LDA);
                  b_we   = is_alu;
                  ram_we = (opcode == OP_STA);
                end
                T8: begin
                  alu_oe  = is_alu;
                  alu_sub = (opcode == OP_SUB);
                end
                T9: begin
                  a_we    = is_alu;
                  alu_sub = (opcode == OP_SUB);
                end
                default: ;
              endcase
            end
            OP_LDI, OP_JMP: begin
              ir_oe = (step == T4);
              a_we  = (step == T5) && (opcode == OP_LDI);
              pc_we = (step == T5) && (opcode == OP_JMP);
            end
            OP_JC: begin
              ir_oe = (step == T4) && carry;
              pc_we = (step == T5) && jc_taken;
            end
            OP_OUT: begin
              a_oe   = (step == T4);
              out_we = (step == T5);
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule
